mesh_term_src: RTL and testbench

//  Injection stage for one mesh terminal: accepts packet requests from a local client,

---
 rtl/mesh_pkg.sv | 39 +++
 rtl/mesh_src_fifo.sv | 86 ++++++++
 rtl/mesh_term_src.sv | 127 ++++++++++++
 tb/tb_mesh_term_src.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mesh_pkg.sv
// Shared definitions for the mesh terminal injection path: header field layout,
// header type and the edge-terminal destination check.
package mesh_pkg;

    // Field positions as offsets below the packet width (offset 1 is the packet MSB).
    localparam int NXT_JMP_MSB = 1;
    localparam int ROW_MSB     = 9;
    localparam int COL_MSB     = 13;
    localparam int MODE_BIT    = 17;

    typedef struct packed {
        logic [7:0] nxt_jump;
        logic [3:0] row;
        logic [3:0] col;
        logic       mode;
    } hdr_t;

    function automatic logic is_terminal(
        input logic [3:0] row,
        input logic [3:0] col,
        input int         rows,
        input int         cols
    );
        logic [4:0] row_x;
        logic [4:0] col_x;
        logic       row_in;
        logic       col_in;
        logic       row_edge;
        logic       col_edge;
        row_x    = {1'b0, row};
        col_x    = {1'b0, col};
        row_in   = (row_x >= 5'd1) && (row_x <= 5'(rows));
        col_in   = (col_x >= 5'd1) && (col_x <= 5'(cols));
        row_edge = (row_x == 5'd0) || (row_x == 5'(rows + 32'sd1));
        col_edge = (col_x == 5'd0) || (col_x == 5'(cols + 32'sd1));
        return (row_edge && col_in) || (col_edge && row_in);
    endfunction

endpackage

// File: rtl/mesh_src_fifo.sv
// Register-based synchronous FIFO for the injection queue; exposes the head entry,
// occupancy and a look-ahead full flag so the owner can register its ready output.
module mesh_src_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     empty_o,
    output logic                     full_nxt_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [WIDTH-1:0]         head_o
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = AW + 1;
    localparam logic [AW:0]    FULL_LVL = CW'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = CW'(1);
    localparam logic [AW:0]    CNT_ZERO = CW'(0);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign push_ok_s = push_i & (cnt_q != FULL_LVL);
    assign pop_ok_s  = pop_i & (cnt_q != CNT_ZERO);

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok_s) begin
            wr_d = wr_q + PTR_ONE;
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok_s) begin
            rd_d = rd_q + PTR_ONE;
        end else begin
            rd_d = rd_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= {AW{1'b0}};
            rd_q  <= {AW{1'b0}};
            cnt_q <= CNT_ZERO;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage; cleared on reset so a reset drops every queued packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
        end else if (push_ok_s) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign empty_o    = (cnt_q == CNT_ZERO);
    assign full_nxt_o = (cnt_d == FULL_LVL);
    assign level_o    = cnt_q;
    assign head_o     = empty_o ? {WIDTH{1'b0}} : mem_q[rd_q];

endmodule

// File: rtl/mesh_term_src.sv
// Mesh terminal injection stage: formats and validates client requests, queues them
// and presents them to the router. Optional statistics enabled by MESH_SRC_STATS_EN.
module mesh_term_src
    import mesh_pkg::*;
#(
    parameter int         ROWS       = 4,
    parameter int         COLUMS     = 4,
    parameter int         pckg_sz    = 32,
    parameter int         fifo_depth = 4,
    parameter logic [7:0] bdcst      = 8'hFF,
    parameter int         MY_ROW     = 0,
    parameter int         MY_COL     = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_vld,
    output logic                          req_rdy,
    input  logic [3:0]                    req_row,
    input  logic [3:0]                    req_col,
    input  logic                          req_mode,
    input  logic [pckg_sz-18:0]           req_payload,
    output logic                          req_err,
    output logic [pckg_sz-1:0]            data_out_i_in,
    output logic                          pndng_i_in,
    input  logic                          popin,
    output logic                          pop_err,
    output logic [$clog2(fifo_depth):0]   level,
    output logic [15:0]                   sent_cnt,
    output logic [15:0]                   stall_cnt
);

    localparam logic [3:0] MY_ROW_C = 4'(MY_ROW);
    localparam logic [3:0] MY_COL_C = 4'(MY_COL);

    logic               rdy_q;
    logic               req_err_q;
    logic               pop_err_q;
    logic               full_nxt_s;
    logic               empty_s;
    logic               dest_ok_s;
    logic               self_s;
    logic               hs_s;
    logic               push_s;
    logic               pop_s;
    hdr_t               hdr_s;
    logic [pckg_sz-1:0] pkt_s;

    assign hs_s      = req_vld & rdy_q;
    assign dest_ok_s = is_terminal(req_row, req_col, ROWS, COLUMS) | ({req_row, req_col} == bdcst);
    assign self_s    = (req_row == MY_ROW_C) & (req_col == MY_COL_C);
    assign push_s    = hs_s & dest_ok_s & ~self_s;
    assign pop_s     = popin & ~empty_s;

    // Header formatting; nxt_jump always starts at zero at injection.
    always_comb begin
        hdr_s.nxt_jump = 8'h00;
        hdr_s.row      = req_row;
        hdr_s.col      = req_col;
        hdr_s.mode     = req_mode;
        pkt_s          = {pckg_sz{1'b0}};
        pkt_s[pckg_sz-NXT_JMP_MSB -: 8] = hdr_s.nxt_jump;
        pkt_s[pckg_sz-ROW_MSB -: 4]     = hdr_s.row;
        pkt_s[pckg_sz-COL_MSB -: 4]     = hdr_s.col;
        pkt_s[pckg_sz-MODE_BIT]         = hdr_s.mode;
        pkt_s[pckg_sz-MODE_BIT-1:0]     = req_payload;
    end

    mesh_src_fifo #(
        .WIDTH (pckg_sz),
        .DEPTH (fifo_depth)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (push_s),
        .data_i     (pkt_s),
        .pop_i      (pop_s),
        .empty_o    (empty_s),
        .full_nxt_o (full_nxt_s),
        .level_o    (level),
        .head_o     (data_out_i_in)
    );

    // Ready follows next occupancy, so a pop while full reopens ready only a cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdy_q     <= 1'b0;
            req_err_q <= 1'b0;
            pop_err_q <= 1'b0;
        end else begin
            rdy_q     <= ~full_nxt_s;
            req_err_q <= hs_s & ~(dest_ok_s & ~self_s);
            pop_err_q <= popin & empty_s;
        end
    end

    assign req_rdy    = rdy_q;
    assign req_err    = req_err_q;
    assign pop_err    = pop_err_q;
    assign pndng_i_in = ~empty_s;

`ifdef MESH_SRC_STATS_EN
    logic [15:0] sent_q;
    logic [15:0] stall_q;

    // Saturating delivery and back-pressure counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sent_q  <= 16'h0000;
            stall_q <= 16'h0000;
        end else begin
            if (pop_s && (sent_q != 16'hFFFF)) begin
                sent_q <= sent_q + 16'd1;
            end
            if (req_vld && !rdy_q && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign sent_cnt  = sent_q;
    assign stall_cnt = stall_q;
`else
    assign sent_cnt  = 16'h0000;
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mesh_term_src.sv
// Self-checking bench for mesh_term_src: table of single requests plus hand-written
// fill/drain, error and reset sequences, with a queue scoreboard for packet order.
module tb_mesh_term_src;

`ifdef MESH_SRC_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req_vld;
    logic        req_rdy;
    logic [3:0]  req_row;
    logic [3:0]  req_col;
    logic        req_mode;
    logic [14:0] req_payload;
    logic        req_err;
    logic [31:0] data_out_i_in;
    logic        pndng_i_in;
    logic        popin;
    logic        pop_err;
    logic [2:0]  level;
    logic [15:0] sent_cnt;
    logic [15:0] stall_cnt;

    mesh_term_src dut (
        .clk           (clk),
        .reset         (reset),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .req_row       (req_row),
        .req_col       (req_col),
        .req_mode      (req_mode),
        .req_payload   (req_payload),
        .req_err       (req_err),
        .data_out_i_in (data_out_i_in),
        .pndng_i_in    (pndng_i_in),
        .popin         (popin),
        .pop_err       (pop_err),
        .level         (level),
        .sent_cnt      (sent_cnt),
        .stall_cnt     (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  row;
        logic [3:0]  col;
        logic        mode;
        logic [14:0] pl;
        logic        ok;
        logic [31:0] pkt;
    } vec_t;

    vec_t        vecs [11];
    logic [31:0] sb [$];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          m_sent = 0;
    int          m_stall = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [3:0] r, input logic [3:0] c, input logic m, input logic [14:0] p);
        req_vld     = 1'b1;
        req_row     = r;
        req_col     = c;
        req_mode    = m;
        req_payload = p;
    endtask

    function automatic logic [31:0] mk_pkt(input logic [3:0] r, input logic [3:0] c, input logic m, input logic [14:0] p);
        return {8'h00, r, c, m, p};
    endfunction

    task automatic pop_check(input string nm);
        logic [31:0] e;
        chk({nm, "_pndng"}, {31'd0, pndng_i_in}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(nm, data_out_i_in, e);
        end else begin
            n_tot++;
            $display("FAIL %s: scoreboard empty, data %h", nm, data_out_i_in);
        end
    endtask

    task automatic chk_stats(input string nm);
        chk({nm, "_sent"},  {16'd0, sent_cnt},  STATS ? 32'(m_sent)  : 32'd0);
        chk({nm, "_stall"}, {16'd0, stall_cnt}, STATS ? 32'(m_stall) : 32'd0);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_rdy"},   {31'd0, req_rdy},    32'd0);
        chk({nm, "_pndng"}, {31'd0, pndng_i_in}, 32'd0);
        chk({nm, "_data"},  data_out_i_in,       32'd0);
        chk({nm, "_err"},   {31'd0, req_err},    32'd0);
        chk({nm, "_perr"},  {31'd0, pop_err},    32'd0);
        chk({nm, "_level"}, {29'd0, level},      32'd0);
        chk({nm, "_sent"},  {16'd0, sent_cnt},   32'd0);
        chk({nm, "_stall"}, {16'd0, stall_cnt},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{4'd0,  4'd3, 1'b1, 15'd5,      1'b1, 32'h0003_8005};
        vecs[1]  = '{4'd5,  4'd2, 1'b0, 15'h1234,   1'b1, 32'h0052_1234};
        vecs[2]  = '{4'd2,  4'd0, 1'b1, 15'h7FFF,   1'b1, 32'h0020_FFFF};
        vecs[3]  = '{4'd3,  4'd5, 1'b0, 15'd1,      1'b1, 32'h0035_0001};
        vecs[4]  = '{4'd2,  4'd2, 1'b0, 15'd7,      1'b0, 32'h0};
        vecs[5]  = '{4'd0,  4'd1, 1'b1, 15'd9,      1'b0, 32'h0};
        vecs[6]  = '{4'd0,  4'd0, 1'b0, 15'd3,      1'b0, 32'h0};
        vecs[7]  = '{4'hF,  4'hF, 1'b1, 15'h00AA,   1'b1, 32'h00FF_80AA};
        vecs[8]  = '{4'd0,  4'd4, 1'b0, 15'd3,      1'b1, 32'h0004_0003};
        vecs[9]  = '{4'd6,  4'd1, 1'b0, 15'd2,      1'b0, 32'h0};
        vecs[10] = '{4'd0,  4'd5, 1'b1, 15'd4,      1'b0, 32'h0};

        reset = 1'b0; req_vld = 1'b0; req_row = 4'd0; req_col = 4'd0;
        req_mode = 1'b0; req_payload = 15'd0; popin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b1;
        #1;
        chk("rdy_before_edge", {31'd0, req_rdy}, 32'd0);
        tick();
        chk("rdy_after_release", {31'd0, req_rdy}, 32'd1);

        // Single requests: validation, format, latency, error pulse width.
        for (int i = 0; i < 11; i++) begin
            drive_req(vecs[i].row, vecs[i].col, vecs[i].mode, vecs[i].pl);
            tick();
            req_vld = 1'b0;
            chk($sformatf("v%0d_err", i),   {31'd0, req_err},    {31'd0, ~vecs[i].ok});
            chk($sformatf("v%0d_pndng", i), {31'd0, pndng_i_in}, {31'd0, vecs[i].ok});
            chk($sformatf("v%0d_level", i), {29'd0, level},      vecs[i].ok ? 32'd1 : 32'd0);
            if (vecs[i].ok) sb.push_back(vecs[i].pkt);
            tick();
            chk($sformatf("v%0d_err_clr", i), {31'd0, req_err}, 32'd0);
            if (pndng_i_in) begin
                popin = 1'b1;
                pop_check($sformatf("v%0d_data", i));
                tick();
                popin = 1'b0;
                m_sent++;
                chk($sformatf("v%0d_drained", i), {29'd0, level}, 32'd0);
            end
        end
        chk_stats("vectors");

        // Fill to full, then hold a request against back-pressure.
        for (int k = 0; k < 4; k++) begin
            drive_req(4'd0, 4'd2, k[0], 15'h100 + 15'(k));
            sb.push_back(mk_pkt(4'd0, 4'd2, k[0], 15'h100 + 15'(k)));
            tick();
            chk($sformatf("fill%0d_level", k), {29'd0, level},   32'(k + 1));
            chk($sformatf("fill%0d_rdy", k),   {31'd0, req_rdy}, (k == 3) ? 32'd0 : 32'd1);
        end
        drive_req(4'd0, 4'd2, 1'b0, 15'h1FF);
        for (int j = 0; j < 3; j++) begin
            tick();
            m_stall++;
            chk($sformatf("stall%0d_level", j), {29'd0, level}, 32'd4);
            chk_stats($sformatf("stall%0d", j));
        end
        req_vld = 1'b0;

        // Drain in order; a pop while full must not bypass into ready.
        popin = 1'b1;
        chk("no_bypass_rdy", {31'd0, req_rdy}, 32'd0);
        for (int j = 0; j < 4; j++) begin
            pop_check($sformatf("drain%0d", j));
            tick();
            m_sent++;
            chk($sformatf("drain%0d_level", j), {29'd0, level},   32'(3 - j));
            chk($sformatf("drain%0d_rdy", j),   {31'd0, req_rdy}, 32'd1);
        end
        popin = 1'b0;
        chk("drain_pndng", {31'd0, pndng_i_in}, 32'd0);
        chk_stats("drain");

        // Simultaneous push and pop with one entry queued.
        drive_req(4'd1, 4'd0, 1'b1, 15'h0A1);
        sb.push_back(mk_pkt(4'd1, 4'd0, 1'b1, 15'h0A1));
        tick();
        drive_req(4'd3, 4'd5, 1'b0, 15'h0B2);
        sb.push_back(mk_pkt(4'd3, 4'd5, 1'b0, 15'h0B2));
        popin = 1'b1;
        pop_check("pp_first");
        tick();
        req_vld = 1'b0;
        m_sent++;
        chk("pp_level", {29'd0, level}, 32'd1);
        pop_check("pp_second");
        tick();
        popin = 1'b0;
        m_sent++;
        chk("pp_level_end", {29'd0, level}, 32'd0);

        // Back-to-back rejects: interior node then self.
        drive_req(4'd2, 4'd2, 1'b0, 15'd1);
        tick();
        chk("rej1_err", {31'd0, req_err}, 32'd1);
        drive_req(4'd0, 4'd1, 1'b0, 15'd2);
        tick();
        req_vld = 1'b0;
        chk("rej2_err", {31'd0, req_err}, 32'd1);
        chk("rej2_rdy", {31'd0, req_rdy}, 32'd1);
        tick();
        chk("rej_err_clr", {31'd0, req_err}, 32'd0);
        chk("rej_level",   {29'd0, level},   32'd0);

        // Pop while empty.
        popin = 1'b1;
        tick();
        popin = 1'b0;
        chk("perr_pulse", {31'd0, pop_err},    32'd1);
        chk("perr_level", {29'd0, level},      32'd0);
        chk("perr_pndng", {31'd0, pndng_i_in}, 32'd0);
        tick();
        chk("perr_clr", {31'd0, pop_err}, 32'd0);
        chk_stats("perr");

        // Broadcast queued, then asynchronous reset mid-queue.
        drive_req(4'hF, 4'hF, 1'b1, 15'h00AA);
        tick();
        drive_req(4'd0, 4'd2, 1'b0, 15'h011);
        tick();
        req_vld = 1'b0;
        chk("bc_level", {29'd0, level},   32'd2);
        chk("bc_head",  data_out_i_in,    32'h00FF_80AA);
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("async_rst");
        sb.delete();
        m_sent = 0;
        m_stall = 0;
        reset = 1'b1;
        tick();
        chk("post_rst_rdy",   {31'd0, req_rdy},    32'd1);
        chk("post_rst_pndng", {31'd0, pndng_i_in}, 32'd0);
        chk("post_rst_level", {29'd0, level},      32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
